// File: rtl/forward_record_source.sv
`default_nettype none
// ============================================================================
//  Module      : forward_record_source
//  Description : Write-back end of the forwarding path. Holds one committed
//                table operation, issues the per-table memory writes and
//                emits a one-cycle forwarding record per committed operation.
//  Revision    : 1.0  initial release
// ============================================================================
module forward_record_source #(
    parameter int DATA_WIDTH         = 4,
    parameter int KEY_WIDTH          = 2,
    parameter int NUMBER_OF_TABLES   = 4,
    parameter int MAX_HASH_ADR_WIDTH = 2,
    parameter int TIDX_WIDTH         = 2,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    clk_en,
    input  logic                                                    op_valid_i,
    output logic                                                    op_ready_o,
    input  logic [1:0]                                              op_kind_i,
    input  logic [TIDX_WIDTH-1:0]                                   op_table_i,
    input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]     op_hash_adr_i,
    input  logic [KEY_WIDTH-1:0]                                    op_key_i,
    input  logic [DATA_WIDTH-1:0]                                   op_data_i,
    input  logic [KEY_WIDTH-1:0]                                    op_evict_key_i,
    input  logic [DATA_WIDTH-1:0]                                   op_evict_data_i,
    output logic [NUMBER_OF_TABLES-1:0]                             mem_we_o,
    output logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]     mem_adr_o,
    output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]              mem_key_o,
    output logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]             mem_data_o,
    output logic [NUMBER_OF_TABLES-1:0]                             mem_valid_o,
    input  logic                                                    mem_ready_i,
    output logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]     forward_hash_adr_o,
    output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]              forward_key_o,
    output logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]             forward_data_o,
    output logic [NUMBER_OF_TABLES-1:0]                             forward_updated_mem_o,
    output logic [NUMBER_OF_TABLES-1:0]                             forward_valid_o,
    output logic [NUMBER_OF_TABLES-2:0][MAX_HASH_ADR_WIDTH-1:0]     forward_shift_hash_adr_o,
    output logic [NUMBER_OF_TABLES-2:0]                             forward_shift_valid_o,
    output logic [CNT_WIDTH-1:0]                                    ops_committed_o,
    output logic                                                    err_o
);

    localparam int NT = NUMBER_OF_TABLES;
    localparam logic [1:0] KIND_NOP    = 2'd0;
    localparam logic [1:0] KIND_INSERT = 2'd1;
    localparam logic [1:0] KIND_DELETE = 2'd2;
    localparam logic [1:0] KIND_KICK   = 2'd3;

    // Decoded write set of the offered operation
    logic [NT-1:0]                          dec_we;
    logic [NT-1:0][MAX_HASH_ADR_WIDTH-1:0]  dec_adr;
    logic [NT-1:0][KEY_WIDTH-1:0]           dec_key;
    logic [NT-1:0][DATA_WIDTH-1:0]          dec_data;
    logic [NT-1:0]                          dec_valid;
    logic [NT-2:0]                          dec_shift;
    logic                                   table_ok;
    logic                                   takes_slot;
    logic                                   illegal;

    // Stage register S (holds the decoded write set)
    logic                                   s_full;
    logic [NT-1:0]                          s_we;
    logic [NT-1:0][MAX_HASH_ADR_WIDTH-1:0]  s_adr;
    logic [NT-1:0][KEY_WIDTH-1:0]           s_key;
    logic [NT-1:0][DATA_WIDTH-1:0]          s_data;
    logic [NT-1:0]                          s_valid;
    logic [NT-2:0]                          s_shift;
    logic [NT-2:0][MAX_HASH_ADR_WIDTH-1:0]  shift_adr_sel;

    logic accept;
    logic commit;

    assign op_ready_o = reset & clk_en & (~s_full | mem_ready_i);
    assign accept     = op_valid_i & op_ready_o;
    assign commit     = reset & clk_en & s_full & mem_ready_i;

    // Translate the offered operation into per-table writes; a KICK on the
    // last table has no successor and degrades to an INSERT.
    always_comb begin
        dec_we    = '0;
        dec_adr   = '0;
        dec_key   = '0;
        dec_data  = '0;
        dec_valid = '0;
        dec_shift = '0;
        table_ok  = (int'(op_table_i) < NT);
        for (int i = 0; i < NT; i++) begin
            if (int'(op_table_i) == i) begin
                case (op_kind_i)
                    KIND_INSERT, KIND_KICK: begin
                        dec_we[i]    = 1'b1;
                        dec_adr[i]   = op_hash_adr_i[i];
                        dec_key[i]   = op_key_i;
                        dec_data[i]  = op_data_i;
                        dec_valid[i] = 1'b1;
                    end
                    KIND_DELETE: begin
                        dec_we[i]  = 1'b1;
                        dec_adr[i] = op_hash_adr_i[i];
                    end
                    default: ;
                endcase
            end
            if (op_kind_i == KIND_KICK && int'(op_table_i) == i - 1) begin
                dec_we[i]    = 1'b1;
                dec_adr[i]   = op_hash_adr_i[i];
                dec_key[i]   = op_evict_key_i;
                dec_data[i]  = op_evict_data_i;
                dec_valid[i] = 1'b1;
            end
        end
        for (int i = 0; i < NT - 1; i++) begin
            dec_shift[i] = (op_kind_i == KIND_KICK) && (int'(op_table_i) == i);
        end
        takes_slot = table_ok && (op_kind_i != KIND_NOP);
        illegal    = ((op_kind_i == KIND_KICK) && (int'(op_table_i) == NT - 1)) ||
                     (!table_ok && (op_kind_i != KIND_NOP));
    end

    // Shift destination address is the write address in the next table
    generate
        for (genvar g = 0; g < NT - 1; g++) begin : g_shift_adr
            assign shift_adr_sel[g] = s_shift[g] ? s_adr[g+1] : '0;
        end
    endgenerate

    assign mem_we_o    = (s_full & clk_en) ? s_we : '0;
    assign mem_adr_o   = s_adr;
    assign mem_key_o   = s_key;
    assign mem_data_o  = s_data;
    assign mem_valid_o = s_valid;

    // Stage register: load on accept of a writing op, empty on commit
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_full  <= 1'b0;
            s_we    <= '0;
            s_adr   <= '0;
            s_key   <= '0;
            s_data  <= '0;
            s_valid <= '0;
            s_shift <= '0;
        end else if (clk_en) begin
            if (accept && takes_slot) begin
                s_full  <= 1'b1;
                s_we    <= dec_we;
                s_adr   <= dec_adr;
                s_key   <= dec_key;
                s_data  <= dec_data;
                s_valid <= dec_valid;
                s_shift <= dec_shift;
            end else if (commit) begin
                s_full <= 1'b0;
            end
        end
    end

    // Forward record: live for exactly one cycle after each commit
    always_ff @(posedge clk) begin
        if (!reset) begin
            forward_hash_adr_o       <= '0;
            forward_key_o            <= '0;
            forward_data_o           <= '0;
            forward_updated_mem_o    <= '0;
            forward_valid_o          <= '0;
            forward_shift_hash_adr_o <= '0;
            forward_shift_valid_o    <= '0;
        end else if (clk_en) begin
            if (commit) begin
                forward_hash_adr_o       <= s_adr;
                forward_key_o            <= s_key;
                forward_data_o           <= s_data;
                forward_updated_mem_o    <= s_we;
                forward_valid_o          <= s_valid;
                forward_shift_hash_adr_o <= shift_adr_sel;
                forward_shift_valid_o    <= s_shift;
            end else begin
                forward_hash_adr_o       <= '0;
                forward_key_o            <= '0;
                forward_data_o           <= '0;
                forward_updated_mem_o    <= '0;
                forward_valid_o          <= '0;
                forward_shift_hash_adr_o <= '0;
                forward_shift_valid_o    <= '0;
            end
        end
    end

    // Commit counter and sticky illegal-op flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            ops_committed_o <= '0;
            err_o           <= 1'b0;
        end else if (clk_en) begin
            if (commit) begin
                ops_committed_o <= ops_committed_o + 1'b1;
            end
            if (accept && illegal) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_forward_record_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_forward_record_source
//  Description : Randomized self-checking bench for forward_record_source
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_forward_record_source;

    localparam int DW = 4;
    localparam int KW = 2;
    localparam int NT = 3;
    localparam int AW = 2;
    localparam int TW = 2;
    localparam int CW = 16;
    localparam int N_CYCLES = 3000;

    typedef struct packed {
        logic [NT-1:0]          we;
        logic [NT-1:0][AW-1:0]  adr;
        logic [NT-1:0][KW-1:0]  key;
        logic [NT-1:0][DW-1:0]  data;
        logic [NT-1:0]          valid;
        logic [NT-2:0]          sh;
    } rec_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clk_en;
    logic                   op_valid_i;
    logic                   op_ready_o;
    logic [1:0]             op_kind_i;
    logic [TW-1:0]          op_table_i;
    logic [NT-1:0][AW-1:0]  op_hash_adr_i;
    logic [KW-1:0]          op_key_i;
    logic [DW-1:0]          op_data_i;
    logic [KW-1:0]          op_evict_key_i;
    logic [DW-1:0]          op_evict_data_i;
    logic [NT-1:0]          mem_we_o;
    logic [NT-1:0][AW-1:0]  mem_adr_o;
    logic [NT-1:0][KW-1:0]  mem_key_o;
    logic [NT-1:0][DW-1:0]  mem_data_o;
    logic [NT-1:0]          mem_valid_o;
    logic                   mem_ready_i;
    logic [NT-1:0][AW-1:0]  forward_hash_adr_o;
    logic [NT-1:0][KW-1:0]  forward_key_o;
    logic [NT-1:0][DW-1:0]  forward_data_o;
    logic [NT-1:0]          forward_updated_mem_o;
    logic [NT-1:0]          forward_valid_o;
    logic [NT-2:0][AW-1:0]  forward_shift_hash_adr_o;
    logic [NT-2:0]          forward_shift_valid_o;
    logic [CW-1:0]          ops_committed_o;
    logic                   err_o;

    forward_record_source #(
        .DATA_WIDTH         (DW),
        .KEY_WIDTH          (KW),
        .NUMBER_OF_TABLES   (NT),
        .MAX_HASH_ADR_WIDTH (AW),
        .TIDX_WIDTH         (TW),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .clk_en                   (clk_en),
        .op_valid_i               (op_valid_i),
        .op_ready_o               (op_ready_o),
        .op_kind_i                (op_kind_i),
        .op_table_i               (op_table_i),
        .op_hash_adr_i            (op_hash_adr_i),
        .op_key_i                 (op_key_i),
        .op_data_i                (op_data_i),
        .op_evict_key_i           (op_evict_key_i),
        .op_evict_data_i          (op_evict_data_i),
        .mem_we_o                 (mem_we_o),
        .mem_adr_o                (mem_adr_o),
        .mem_key_o                (mem_key_o),
        .mem_data_o               (mem_data_o),
        .mem_valid_o              (mem_valid_o),
        .mem_ready_i              (mem_ready_i),
        .forward_hash_adr_o       (forward_hash_adr_o),
        .forward_key_o            (forward_key_o),
        .forward_data_o           (forward_data_o),
        .forward_updated_mem_o    (forward_updated_mem_o),
        .forward_valid_o          (forward_valid_o),
        .forward_shift_hash_adr_o (forward_shift_hash_adr_o),
        .forward_shift_valid_o    (forward_shift_valid_o),
        .ops_committed_o          (ops_committed_o),
        .err_o                    (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    rec_t          pend[$];
    rec_t          fwd_exp;
    logic          err_exp;
    logic [CW-1:0] cnt_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Writes an operation produces, straight from the op definitions
    function automatic rec_t build(input logic [1:0] kind, input int t);
        rec_t r = '0;
        if (kind == 2'd1 || (kind == 2'd3 && t == NT - 1)) begin
            r.we[t] = 1'b1; r.adr[t] = op_hash_adr_i[t];
            r.key[t] = op_key_i; r.data[t] = op_data_i; r.valid[t] = 1'b1;
        end else if (kind == 2'd2) begin
            r.we[t] = 1'b1; r.adr[t] = op_hash_adr_i[t];
        end else if (kind == 2'd3) begin
            r.we[t] = 1'b1; r.adr[t] = op_hash_adr_i[t];
            r.key[t] = op_key_i; r.data[t] = op_data_i; r.valid[t] = 1'b1;
            r.we[t+1] = 1'b1; r.adr[t+1] = op_hash_adr_i[t+1];
            r.key[t+1] = op_evict_key_i; r.data[t+1] = op_evict_data_i; r.valid[t+1] = 1'b1;
            r.sh[t] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        logic                  occ;
        logic                  exp_ready;
        logic [NT-1:0]         exp_we;
        logic [NT-2:0][AW-1:0] exp_sh_adr;

        reset = 1'b0; clk_en = 1'b0; op_valid_i = 1'b0; op_kind_i = '0; op_table_i = '0;
        op_hash_adr_i = '0; op_key_i = '0; op_data_i = '0; op_evict_key_i = '0;
        op_evict_data_i = '0; mem_ready_i = 1'b0;
        fwd_exp = '0; err_exp = 1'b0; cnt_exp = '0;
        repeat (3) @(posedge clk);

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            reset           = (cyc < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
            clk_en          = ($urandom_range(0, 9) != 0);
            mem_ready_i     = ($urandom_range(0, 9) < 7);
            op_valid_i      = ($urandom_range(0, 9) < 7);
            op_kind_i       = 2'($urandom_range(0, 3));
            op_table_i      = ($urandom_range(0, 9) == 0) ? TW'(3) : TW'($urandom_range(0, NT - 1));
            if (op_kind_i == 2'd0 && int'(op_table_i) >= NT) op_table_i = '0;
            op_hash_adr_i   = ($urandom) & ((1 << (NT * AW)) - 1);
            op_key_i        = KW'($urandom);
            op_data_i       = DW'($urandom);
            op_evict_key_i  = KW'($urandom);
            op_evict_data_i = DW'($urandom);

            @(negedge clk);
            occ       = (pend.size() != 0);
            exp_ready = reset && clk_en && (!occ || mem_ready_i);
            exp_we    = (occ && clk_en) ? pend[0].we : '0;

            check_eq("op_ready", op_ready_o, exp_ready);
            check_eq("mem_we", mem_we_o, exp_we);
            for (int i = 0; i < NT; i++) begin
                if (exp_we[i]) begin
                    check_eq("mem_adr", mem_adr_o[i], pend[0].adr[i]);
                    check_eq("mem_key", mem_key_o[i], pend[0].key[i]);
                    check_eq("mem_data", mem_data_o[i], pend[0].data[i]);
                    check_eq("mem_valid", mem_valid_o[i], pend[0].valid[i]);
                end
            end
            for (int i = 0; i < NT - 1; i++) begin
                exp_sh_adr[i] = fwd_exp.sh[i] ? fwd_exp.adr[i+1] : '0;
            end
            check_eq("fwd_updated_mem", forward_updated_mem_o, fwd_exp.we);
            check_eq("fwd_valid", forward_valid_o, fwd_exp.valid);
            check_eq("fwd_hash_adr", forward_hash_adr_o, fwd_exp.adr);
            check_eq("fwd_key", forward_key_o, fwd_exp.key);
            check_eq("fwd_data", forward_data_o, fwd_exp.data);
            check_eq("fwd_shift_valid", forward_shift_valid_o, fwd_exp.sh);
            check_eq("fwd_shift_adr", forward_shift_hash_adr_o, exp_sh_adr);
            check_eq("err", err_o, err_exp);
            check_eq("ops_committed", ops_committed_o, cnt_exp);

            // Advance the model across the coming clock edge
            if (!reset) begin
                pend.delete();
                fwd_exp = '0; err_exp = 1'b0; cnt_exp = '0;
            end else if (clk_en) begin
                if (occ && mem_ready_i) begin
                    fwd_exp = pend.pop_front();
                    cnt_exp = cnt_exp + 1'b1;
                end else begin
                    fwd_exp = '0;
                end
                if (op_valid_i && exp_ready) begin
                    if (int'(op_table_i) >= NT) begin
                        if (op_kind_i != 2'd0) err_exp = 1'b1;
                    end else begin
                        if (op_kind_i == 2'd3 && int'(op_table_i) == NT - 1) err_exp = 1'b1;
                        if (op_kind_i != 2'd0) pend.push_back(build(op_kind_i, int'(op_table_i)));
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
